weight_uart_load: RTL and testbench

Receive-side counterpart of the weight dump path. It receives a fixed-length stream of weight bytes over a UART line (8N1, LSB first) and writes them into a single-port weight RAM at consecutive addresses starting at 0. After the last byte it pulses `done`. It sits between the board UART RX pin and the weight RAM write port, so weights can be reloaded without resynthesis.

---
 rtl/weight_uart_load.sv | 208 ++++++++++++++++++++
 tb/tb_weight_uart_load.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/weight_uart_load.sv
// UART (8N1, LSB first) receiver that streams a fixed number of bytes into a
// weight RAM at consecutive addresses, then pulses done.
module weight_uart_load #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int SUM_BYTES = 529,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              uart_rxd,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;
  localparam int TW      = $clog2(BPS_CNT + 1);
  localparam int CW      = ADDR_W + 1;
  localparam logic [TW-1:0] T_HALF   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(BPS_CNT - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(SUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            rx_meta_r;
  logic            rx_sync_r;
  logic            rx_prev_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shreg_r;
  logic [CW-1:0]   count_r;
  logic            fall_s;
  logic            last_s;
  logic            arm_s;
  logic            timer_clr_s;
  logic            bit_clr_s;
  logic            shift_s;
  logic            commit_s;
  logic            ferr_set_s;

  assign fall_s   = rx_prev_r & ~rx_sync_r;
  assign last_s   = (count_r == LAST_IDX);
  // Count is one bit wider than the address so a full 2^ADDR_W load cannot wrap.
  assign ram_addr = count_r[ADDR_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_s     = state_r;
    arm_s       = 1'b0;
    timer_clr_s = 1'b0;
    bit_clr_s   = 1'b0;
    shift_s     = 1'b0;
    commit_s    = 1'b0;
    ferr_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        // busy is still high during the final-commit cycle, which masks start there.
        if (start && !busy) begin
          arm_s   = 1'b1;
          state_s = S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (fall_s) begin
          timer_clr_s = 1'b1;
          state_s     = S_START;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_START: begin
        if (timer_r == T_HALF) begin
          if (rx_sync_r) begin
            state_s = S_WAIT;
          end else begin
            timer_clr_s = 1'b1;
            bit_clr_s   = 1'b1;
            state_s     = S_DATA;
          end
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (timer_r == T_FULL) begin
          shift_s     = 1'b1;
          timer_clr_s = 1'b1;
          state_s     = (bit_cnt_r == 3'd7) ? S_STOP : S_DATA;
        end else begin
          state_s = S_DATA;
        end
      end
      S_STOP: begin
        if (timer_r == T_FULL) begin
          if (rx_sync_r) begin
            commit_s = 1'b1;
            state_s  = last_s ? S_IDLE : S_WAIT;
          end else begin
            ferr_set_s = 1'b1;
            state_s    = S_WAIT;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Synchronizer, bit timer and receive shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      timer_r   <= {TW{1'b0}};
      bit_cnt_r <= 3'd0;
      shreg_r   <= 8'd0;
    end else begin
      rx_meta_r <= uart_rxd;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      timer_r   <= timer_clr_s ? {TW{1'b0}} : timer_r + TW'(1);
      if (bit_clr_s) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (shift_s) begin
        shreg_r <= {rx_sync_r, shreg_r[7:1]};
      end else begin
        shreg_r <= shreg_r;
      end
    end
  end

  // RAM write port, byte index and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_wdata <= 8'd0;
      count_r   <= {CW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ram_we <= commit_s;
      done   <= commit_s & last_s;
      if (commit_s) begin
        ram_wdata <= shreg_r;
      end else begin
        ram_wdata <= ram_wdata;
      end
      // The index advances only after its write cycle so the address holds during ram_we.
      if (arm_s) begin
        count_r <= {CW{1'b0}};
      end else if (ram_we) begin
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (arm_s) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
      if (arm_s) begin
        frame_err <= 1'b0;
      end else if (ferr_set_s) begin
        frame_err <= 1'b1;
      end else begin
        frame_err <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_weight_uart_load.sv
// Directed bench: UART frames on a shared rxd line feed a 529-byte loader and a
// 16-byte full-address-range loader; a per-DUT queue holds expected writes.
module tb_weight_uart_load;

  localparam int CLK_FREQ = 800000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = CLK_FREQ / UART_BPS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       we1, busy1, done1, ferr1;
  logic [9:0] addr1;
  logic [7:0] wdata1;
  logic       we2, busy2, done2, ferr2;
  logic [3:0] addr2;
  logic [7:0] wdata2;

  int n_checks = 0;
  int n_fail   = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;
  logic [18:0] q1[$];
  logic [12:0] q2[$];

  always #5 clk = ~clk;

  weight_uart_load #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .SUM_BYTES(529), .ADDR_W(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .uart_rxd(rxd), .ram_we(we1), .ram_addr(addr1),
    .ram_wdata(wdata1), .busy(busy1), .done(done1), .frame_err(ferr1));

  weight_uart_load #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .SUM_BYTES(16), .ADDR_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .uart_rxd(rxd), .ram_we(we2), .ram_addr(addr2),
    .ram_wdata(wdata2), .busy(busy2), .done(done2), .frame_err(ferr2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BPS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BPS) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Scoreboard monitor for the 529-byte loader.
  initial begin
    logic [18:0] exp;
    logic        prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("dut1 busy after done", {31'd0, busy1}, 32'd0);
      if (we1 === 1'b1) begin
        chk("dut1 write expected", {31'd0, q1.size() > 0}, 32'd1);
        if (q1.size() > 0) begin
          exp = q1.pop_front();
          chk("dut1 addr/data/done", {13'd0, addr1, wdata1, done1}, {13'd0, exp});
        end
      end else if (done1 === 1'b1) begin
        chk("dut1 done without write", {31'd0, done1}, 32'd0);
      end
      if (done1 === 1'b1) done1_cnt++;
      prev_done = (done1 === 1'b1);
    end
  end

  // Scoreboard monitor for the 16-byte loader.
  initial begin
    logic [12:0] exp;
    forever begin
      @(negedge clk);
      if (we2 === 1'b1) begin
        chk("dut2 write expected", {31'd0, q2.size() > 0}, 32'd1);
        if (q2.size() > 0) begin
          exp = q2.pop_front();
          chk("dut2 addr/data/done", {19'd0, addr2, wdata2, done2}, {19'd0, exp});
        end
      end else if (done2 === 1'b1) begin
        chk("dut2 done without write", {31'd0, done2}, 32'd0);
      end
      if (done2 === 1'b1) done2_cnt++;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset ram_we", {31'd0, we1}, 32'd0);
    chk("reset ram_addr", {22'd0, addr1}, 32'd0);
    chk("reset ram_wdata", {24'd0, wdata1}, 32'd0);
    chk("reset busy", {31'd0, busy1}, 32'd0);
    chk("reset done", {31'd0, done1}, 32'd0);
    chk("reset frame_err", {31'd0, ferr1}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Traffic while idle must not write.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("idle busy", {31'd0, busy1}, 32'd0);

    // Arm, then a bad-stop frame followed by a good one.
    chk("busy before start", {31'd0, busy1}, 32'd0);
    pulse(1);
    chk("busy after start", {31'd0, busy1}, 32'd1);
    send_byte(8'h3C, 1'b0);
    chk("frame_err set", {31'd0, ferr1}, 32'd1);
    q1.push_back({10'd0, 8'h5A, 1'b0});
    send_byte(8'h5A, 1'b1);
    for (int i = 1; i < 5; i++) begin
      q1.push_back({10'(i), 8'(8'h40 + i), 1'b0});
      send_byte(8'(8'h40 + i), 1'b1);
    end
    chk("writes before abort", q1.size(), 32'd0);

    // Reset in the middle of byte 5's data bits.
    rxd = 1'b0;
    repeat (3 * BPS) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort ram_we", {31'd0, we1}, 32'd0);
    chk("abort ram_addr", {22'd0, addr1}, 32'd0);
    chk("abort busy", {31'd0, busy1}, 32'd0);
    chk("abort frame_err", {31'd0, ferr1}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full load; a start pulse at byte 10 must not restart the count.
    pulse(1);
    for (int i = 0; i < 529; i++) begin
      if (i == 10) pulse(1);
      q1.push_back({10'(i), 8'((i * 7) & 255), (i == 528) ? 1'b1 : 1'b0});
      send_byte(8'((i * 7) & 255), 1'b1);
    end
    repeat (4) @(negedge clk);
    chk("full load pending", q1.size(), 32'd0);
    chk("full load done count", done1_cnt, 32'd1);
    chk("full load busy", {31'd0, busy1}, 32'd0);
    chk("full load frame_err", {31'd0, ferr1}, 32'd0);

    // Short low glitch while waiting, then a real byte.
    pulse(1);
    repeat (5) @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch no write", q1.size(), 32'd0);
    q1.push_back({10'd0, 8'hA5, 1'b0});
    send_byte(8'hA5, 1'b1);
    chk("glitch byte pending", q1.size(), 32'd0);
    chk("glitch frame_err", {31'd0, ferr1}, 32'd0);

    // Full address range on the 16-byte loader.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse(2);
    for (int i = 0; i < 16; i++) begin
      q2.push_back({4'(i), 8'hFF, (i == 15) ? 1'b1 : 1'b0});
      send_byte(8'hFF, 1'b1);
    end
    repeat (4) @(negedge clk);
    chk("range pending", q2.size(), 32'd0);
    chk("range done count", done2_cnt, 32'd1);
    chk("range busy", {31'd0, busy2}, 32'd0);
    chk("range dut1 untouched", done1_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
